// File: rtl/jpeg_rle_pkg.sv
// Shared types, constants and magnitude-category encoding for the JPEG
// run-length symbolizer.
package jpeg_rle_pkg;

  typedef enum logic [1:0] {
    ST_DC  = 2'd0,
    ST_AC  = 2'd1,
    ST_ZRL = 2'd2
  } state_t;

  localparam int ZRL_RUN   = 15;
  localparam int EOB_RUN   = 0;
  localparam int BLOCK_LEN = 64;

  typedef struct packed {
    logic [4:0]  size;
    logic [31:0] amp;
  } mag_t;

  // JPEG magnitude category: size is the bit length of |v|; negative values
  // carry (v-1) truncated to size bits, i.e. the one's complement of |v|.
  function automatic mag_t mag_encode(input logic signed [31:0] v);
    logic [31:0] m;
    logic [31:0] mask;
    mag_t        r;
    m      = v[31] ? 32'(-v) : 32'(v);
    r.size = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (m[i]) r.size = 5'(i + 1);
    end
    mask  = ~(32'hFFFF_FFFF << r.size);
    r.amp = v[31] ? ((32'(v) - 32'd1) & mask) : 32'(v);
    return r;
  endfunction

endpackage

// File: rtl/jpeg_mag_cat.sv
// Combinational size/amplitude computation for a signed AMP_W value.
module jpeg_mag_cat
  import jpeg_rle_pkg::*;
#(
  parameter int AMP_W = 13
) (
  input  logic signed [AMP_W-1:0] val,
  output logic        [3:0]       size,
  output logic        [AMP_W-1:0] amp
);

  mag_t enc;
  logic unused_enc;

  // Encode at full width, then keep the bits meaningful for AMP_W.
  always_comb begin
    enc        = mag_encode(32'(val));
    size       = enc.size[3:0];
    amp        = enc.amp[AMP_W-1:0];
    unused_enc = ^{enc.size[4], enc.amp[31:AMP_W]};
  end

endmodule

// File: rtl/jpeg_rle_symbolizer.sv
// Run-length symbolizer: turns 64 zigzag-ordered quantized coefficients per
// block into (run, size, amplitude) symbols, with DC prediction, ZRL and EOB.
module jpeg_rle_symbolizer
  import jpeg_rle_pkg::*;
#(
  parameter int COEF_W = 12,
  parameter int AMP_W  = COEF_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [3:0]        out_run,
  output logic        [3:0]        out_size,
  output logic        [AMP_W-1:0]  out_amp,
  output logic                     out_dc,
  output logic                     out_last
);

  state_t                    state;
  logic        [5:0]         idx;
  logic        [5:0]         zrun;
  logic signed [COEF_W-1:0]  pred;
  logic signed [AMP_W-1:0]   held_val;
  logic                      held_last;

  logic                      slot_free;
  logic                      accept;
  logic                      idx_last;
  logic signed [AMP_W-1:0]   coef_ext;
  logic signed [AMP_W-1:0]   dc_diff;
  logic signed [AMP_W-1:0]   mag_in;
  logic        [3:0]         mc_size;
  logic        [AMP_W-1:0]   mc_amp;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state != ST_ZRL) && slot_free;
  assign accept    = in_valid && in_ready;
  assign idx_last  = (idx == 6'(BLOCK_LEN - 1));
  assign coef_ext  = AMP_W'(in_coef);
  assign dc_diff   = coef_ext - AMP_W'(pred);

  // One magnitude encoder serves the DC difference, live AC and held AC value.
  always_comb begin
    mag_in = coef_ext;
    if (state == ST_ZRL)     mag_in = held_val;
    else if (state == ST_DC) mag_in = dc_diff;
  end

  jpeg_mag_cat #(.AMP_W(AMP_W)) u_mag_cat (
    .val  (mag_in),
    .size (mc_size),
    .amp  (mc_amp)
  );

  // Block FSM with the single registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_DC;
      idx       <= '0;
      zrun      <= '0;
      pred      <= '0;
      held_val  <= '0;
      held_last <= 1'b0;
      out_valid <= 1'b0;
      out_run   <= '0;
      out_size  <= '0;
      out_amp   <= '0;
      out_dc    <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      unique case (state)
        ST_DC: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_dc    <= 1'b1;
            out_run   <= '0;
            out_size  <= mc_size;
            out_amp   <= mc_amp;
            out_last  <= 1'b0;
            pred      <= in_coef;
            zrun      <= '0;
            idx       <= idx + 6'd1;
            state     <= ST_AC;
          end
        end

        ST_AC: begin
          if (accept) begin
            idx <= idx + 6'd1;
            if (in_coef == '0) begin
              if (idx_last) begin
                // Trailing zeros collapse into EOB; any pending run is dropped.
                out_valid <= 1'b1;
                out_dc    <= 1'b0;
                out_run   <= 4'(EOB_RUN);
                out_size  <= '0;
                out_amp   <= '0;
                out_last  <= 1'b1;
                zrun      <= '0;
                state     <= ST_DC;
              end else begin
                zrun <= zrun + 6'd1;
              end
            end else if (zrun >= 6'd16) begin
              // First ZRL goes out with the accept; the coefficient is parked.
              out_valid <= 1'b1;
              out_dc    <= 1'b0;
              out_run   <= 4'(ZRL_RUN);
              out_size  <= '0;
              out_amp   <= '0;
              out_last  <= 1'b0;
              zrun      <= zrun - 6'd16;
              held_val  <= coef_ext;
              held_last <= idx_last;
              state     <= ST_ZRL;
            end else begin
              out_valid <= 1'b1;
              out_dc    <= 1'b0;
              out_run   <= zrun[3:0];
              out_size  <= mc_size;
              out_amp   <= mc_amp;
              out_last  <= idx_last;
              zrun      <= '0;
              state     <= idx_last ? ST_DC : ST_AC;
            end
          end
        end

        ST_ZRL: begin
          if (slot_free) begin
            out_valid <= 1'b1;
            out_dc    <= 1'b0;
            if (zrun >= 6'd16) begin
              out_run  <= 4'(ZRL_RUN);
              out_size <= '0;
              out_amp  <= '0;
              out_last <= 1'b0;
              zrun     <= zrun - 6'd16;
            end else begin
              out_run  <= zrun[3:0];
              out_size <= mc_size;
              out_amp  <= mc_amp;
              out_last <= held_last;
              zrun     <= '0;
              state    <= held_last ? ST_DC : ST_AC;
            end
          end
        end

        default: state <= ST_DC;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_rle_symbolizer.sv
// Directed and model-checked bench for jpeg_rle_symbolizer.
module tb_jpeg_rle_symbolizer;

  localparam int COEF_W = 12;
  localparam int AMP_W  = 13;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [COEF_W-1:0] in_coef;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_run;
  logic [3:0]        out_size;
  logic [AMP_W-1:0]  out_amp;
  logic              out_dc;
  logic              out_last;

  always #5 clk = ~clk;

  jpeg_rle_symbolizer #(.COEF_W(COEF_W), .AMP_W(AMP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_run   (out_run),
    .out_size  (out_size),
    .out_amp   (out_amp),
    .out_dc    (out_dc),
    .out_last  (out_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(int run, int size, int amp, bit dc, bit last);
    return {9'b0, 4'(run), 4'(size), 13'(amp), dc, last};
  endfunction

  logic [31:0] cur_sym;
  assign cur_sym = {9'b0, out_run, out_size, out_amp, out_dc, out_last};

  logic [31:0] rx_q[$];
  logic [31:0] exp_q[$];
  int          rdy_low = 0;
  int          acc_cycles = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] sym_prev = '0;
  bit          rand_ready = 1'b0;
  int          blk[64];
  int          mpred = 0;

  // Output monitor: collect handshaken symbols, verify stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", cur_sym, sym_prev);
      end
      if (out_valid && out_ready) rx_q.push_back(cur_sym);
      if (!in_ready) rdy_low++;
      stall_prev = out_valid && !out_ready;
      sym_prev   = cur_sym;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_block();
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < 64) begin
      in_valid = 1'b1;
      in_coef  = 12'(blk[i]);
      @(negedge clk);
      acc = in_ready;
      step();
      acc_cycles++;
      if (acc) i++;
      guard++;
      if (guard > 2000) begin
        check("in_ready_timeout", 32'(i), 32'd64);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int guard = 0;
    while (rx_q.size() < n && guard < 400) begin
      step();
      guard++;
    end
    repeat (4) step();
  endtask

  task automatic expect_syms(input string name);
    check({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s[%0d]", name, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic model_push(input int run, input int v, input bit dc, input bit last);
    int m = (v < 0) ? -v : v;
    int s = 0;
    int a;
    while (m > 0) begin
      s++;
      m = m >> 1;
    end
    a = (v >= 0) ? v : ((v - 1) & ((1 << s) - 1));
    exp_q.push_back(pack(run, s, a, dc, last));
  endtask

  task automatic model_block();
    int z = 0;
    model_push(0, blk[0] - mpred, 1'b1, 1'b0);
    mpred = blk[0];
    for (int k = 1; k < 64; k++) begin
      if (blk[k] == 0) begin
        if (k == 63) exp_q.push_back(pack(0, 0, 0, 1'b0, 1'b1));
        else z++;
      end else begin
        while (z >= 16) begin
          exp_q.push_back(pack(15, 0, 0, 1'b0, 1'b0));
          z -= 16;
        end
        model_push(z, blk[k], 1'b0, k == 63);
        z = 0;
      end
    end
  endtask

  task automatic clear_blk();
    for (int k = 0; k < 64; k++) blk[k] = 0;
  endtask

  initial begin
    bit hit;
    int i;
    int guard;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_coef   = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fields", cur_sym, 32'd0);
    #10 rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Blocks 1 and 2 back to back: no bubble between them.
    acc_cycles = 0;
    clear_blk(); blk[0] = 5; blk[1] = -3;
    send_block();
    clear_blk(); blk[0] = 2;
    send_block();
    check("b2b_cycles", 32'(acc_cycles), 32'd128);
    exp_q.push_back(pack(0, 3, 5, 1'b1, 1'b0));
    exp_q.push_back(pack(0, 2, 0, 1'b0, 1'b0));
    exp_q.push_back(pack(0, 0, 0, 1'b0, 1'b1));
    exp_q.push_back(pack(0, 2, 0, 1'b1, 1'b0));
    exp_q.push_back(pack(0, 0, 0, 1'b0, 1'b1));
    drain(5);
    expect_syms("blk12");

    // 35 zeros then 7 at idx 36.
    rdy_low = 0;
    acc_cycles = 0;
    clear_blk(); blk[0] = 2; blk[36] = 7;
    send_block();
    check("zrl_cycles", 32'(acc_cycles), 32'd66);
    check("zrl_ready_low", 32'(rdy_low), 32'd2);
    exp_q.push_back(pack(0, 0, 0, 1'b1, 1'b0));
    exp_q.push_back(pack(15, 0, 0, 1'b0, 1'b0));
    exp_q.push_back(pack(15, 0, 0, 1'b0, 1'b0));
    exp_q.push_back(pack(3, 3, 7, 1'b0, 1'b0));
    exp_q.push_back(pack(0, 0, 0, 1'b0, 1'b1));
    drain(5);
    expect_syms("blk3");

    // -1 after 41 zeros, then idx 63 = 1 after 20 zeros: no EOB.
    clear_blk(); blk[0] = 2; blk[42] = -1; blk[63] = 1;
    send_block();
    exp_q.push_back(pack(0, 0, 0, 1'b1, 1'b0));
    exp_q.push_back(pack(15, 0, 0, 1'b0, 1'b0));
    exp_q.push_back(pack(15, 0, 0, 1'b0, 1'b0));
    exp_q.push_back(pack(9, 1, 0, 1'b0, 1'b0));
    exp_q.push_back(pack(15, 0, 0, 1'b0, 1'b0));
    exp_q.push_back(pack(4, 1, 1, 1'b0, 1'b1));
    drain(6);
    expect_syms("blk4");

    // Reset pulse while the ZRL state holds in_ready low.
    clear_blk(); blk[0] = 9; blk[41] = 3;
    hit = 1'b0; i = 0; guard = 0;
    in_valid = 1'b1;
    while (!hit && guard < 200 && i < 64) begin
      in_coef = 12'(blk[i]);
      @(negedge clk);
      if (!in_ready) hit = 1'b1;
      else begin
        step();
        i++;
      end
      guard++;
    end
    check("zrl_reached", 32'(hit), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_fields", cur_sym, 32'd0);
    in_valid = 1'b0;
    #10 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    step();
    rx_q.delete();
    exp_q.delete();
    mpred = 0;
    clear_blk(); blk[0] = 4;
    model_block();
    check("post_rst_dc_model", exp_q[0], pack(0, 3, 4, 1'b1, 1'b0));
    send_block();
    drain(2);
    expect_syms("post_rst");

    // Random blocks with random back-pressure against the model.
    rand_ready = 1'b1;
    for (int b = 0; b < 100; b++) begin
      for (int k = 0; k < 64; k++) begin
        if ($urandom_range(0, 9) < 8) blk[k] = 0;
        else blk[k] = int'($urandom_range(0, 4095)) - 2048;
      end
      if (b % 10 == 3) blk[63] = 0;
      model_block();
      send_block();
      drain(exp_q.size());
      expect_syms($sformatf("rand%0d", b));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
